des3_encrypt_hs: RTL and testbench

- Triple-DES encryptor: E(key0) → D(key1) → E(key2).
- Accepts one 64-bit plaintext block and three keys through a valid/ready handshake, runs the three DES stages in sequence, and returns the ciphertext through a valid/ready handshake with backpressure.
- Transmit-side counterpart to the 3DES decryptor.
- Built from one `des_decrypt` and two `des_encrypt` instances.

---
 rtl/des3_encrypt_hs.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_des3_encrypt_hs.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/des3_encrypt_hs.sv
// Triple-DES encryptor E(key0) -> D(key1) -> E(key2) with valid/ready handshakes on both sides.
// Optional key odd-parity check enabled by defining DES3_ENC_KEY_PARITY_EN.

// Iterative DES core, one Feistel round per clock.
// Latency: 17 cycles from select to the done pulse.
// No backpressure: data_out holds the result after done until the next select.
module des_core #(
    parameter bit DECRYPT = 1'b0
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        select,
    input  logic [63:0] data_in,
    input  logic [63:0] key,
    output logic        done,
    output logic [63:0] data_out
);
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // S1..S8, each 4 rows x 16 columns, row = outer bits, column = middle bits
    localparam logic [3:0] SBOX [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    function automatic logic [63:0] perm_ip(input logic [63:0] d);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - IP_T[i])];
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] d);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - FP_T[i])];
        return o;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] k);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_T[i])];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] cd);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
        return o;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  b;
        for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[i])];
        x = x ^ k;
        for (int n = 0; n < 8; n++) begin
            b = x[6'(42 - 6 * n) +: 6];
            s[5'(28 - 4 * n) +: 4] = SBOX[{3'(n), b[5], b[0], b[4:1]}];
        end
        for (int i = 0; i < 32; i++) o[5'(31 - i)] = s[5'(32 - P_T[i])];
        return o;
    endfunction

    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q, c_rot, d_rot;
    logic [3:0]  round_q, sched_idx;
    logic        run_q, two_shift;
    logic [47:0] subkey;

    // Decryption walks the schedule backwards: use the current halves, then rotate right.
    always_comb begin
        sched_idx = DECRYPT ? (4'd15 - round_q) : round_q;
        two_shift = !(sched_idx == 4'd0 || sched_idx == 4'd1 || sched_idx == 4'd8 || sched_idx == 4'd15);
        if (DECRYPT) begin
            c_rot  = two_shift ? {c_q[1:0], c_q[27:2]} : {c_q[0], c_q[27:1]};
            d_rot  = two_shift ? {d_q[1:0], d_q[27:2]} : {d_q[0], d_q[27:1]};
            subkey = perm_pc2({c_q, d_q});
        end else begin
            c_rot  = two_shift ? {c_q[25:0], c_q[27:26]} : {c_q[26:0], c_q[27]};
            d_rot  = two_shift ? {d_q[25:0], d_q[27:26]} : {d_q[26:0], d_q[27]};
            subkey = perm_pc2({c_rot, d_rot});
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            run_q   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (select) begin
                {l_q, r_q} <= perm_ip(data_in);
                {c_q, d_q} <= perm_pc1(key);
                round_q    <= '0;
                run_q      <= 1'b1;
            end else if (run_q) begin
                l_q     <= r_q;
                r_q     <= l_q ^ feistel(r_q, subkey);
                c_q     <= c_rot;
                d_q     <= d_rot;
                round_q <= round_q + 4'd1;
                if (round_q == 4'd15) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign data_out = perm_fp({r_q, l_q});
endmodule

// Single-DES encryption stage.
// Latency: 17 cycles select to done.
// No backpressure; result held until next select.
module des_encrypt (
    input  logic        clock,
    input  logic        rst,
    input  logic        select,
    input  logic [63:0] data_in,
    input  logic [63:0] key,
    output logic        done,
    output logic [63:0] data_out
);
    des_core #(.DECRYPT(1'b0)) u_core (
        .clock(clock), .rst(rst), .select(select), .data_in(data_in),
        .key(key), .done(done), .data_out(data_out));
endmodule

// Single-DES decryption stage.
// Latency: 17 cycles select to done.
// No backpressure; result held until next select.
module des_decrypt (
    input  logic        clock,
    input  logic        rst,
    input  logic        select,
    input  logic [63:0] data_in,
    input  logic [63:0] key,
    output logic        done,
    output logic [63:0] data_out
);
    des_core #(.DECRYPT(1'b1)) u_core (
        .clock(clock), .rst(rst), .select(select), .data_in(data_in),
        .key(key), .done(done), .data_out(data_out));
endmodule

// 3DES EDE encryptor sequencing three DES stages through one intermediate register.
// Latency: 4 + 2*17 + 17 = 55 cycles from acceptance to out_valid.
// Output held while out_ready is low; no new input accepted until back in IDLE.
module des3_encrypt_hs (
    input  logic        clock,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] key0,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_err,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE, START0, RUN0, START1, RUN1, START2, RUN2, OUT
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] data_q, key0_q, key1_q, key2_q, mid_q, res_q;
    logic [63:0] st0_out, st1_out, st2_out;
    logic        sel0, sel1, sel2, done0, done1, done2;
    logic        accept;

`ifdef DES3_ENC_KEY_PARITY_EN
    function automatic logic keys_odd(input logic [63:0] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) ok = ok & (^k[b * 8 +: 8]);
        return ok;
    endfunction

    logic key_bad, err_q;
    assign key_bad = !(keys_odd(key0) && keys_odd(key1) && keys_odd(key2));
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = res_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        sel0    = 1'b0;
        sel1    = 1'b0;
        sel2    = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
`ifdef DES3_ENC_KEY_PARITY_EN
                state_d = key_bad ? OUT : START0;
`else
                state_d = START0;
`endif
            end
            START0: begin sel0 = 1'b1; state_d = RUN0; end
            RUN0:   if (done0) state_d = START1;
            START1: begin sel1 = 1'b1; state_d = RUN1; end
            RUN1:   if (done1) state_d = START2;
            START2: begin sel2 = 1'b1; state_d = RUN2; end
            RUN2:   if (done2) state_d = OUT;
            OUT:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            key0_q  <= '0;
            key1_q  <= '0;
            key2_q  <= '0;
            mid_q   <= '0;
            res_q   <= '0;
`ifdef DES3_ENC_KEY_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= in_data;
                key0_q <= key0;
                key1_q <= key1;
                key2_q <= key2;
            end
            // done is only trusted inside the owning stage's RUN state
            if (state_q == RUN0 && done0) mid_q <= st0_out;
            if (state_q == RUN1 && done1) mid_q <= st1_out;
            if (state_q == RUN2 && done2) res_q <= st2_out;
`ifdef DES3_ENC_KEY_PARITY_EN
            if (accept && key_bad) begin
                res_q <= '0;
                err_q <= 1'b1;
            end
            if (out_valid && out_ready) err_q <= 1'b0;
`endif
        end
    end

    des_encrypt u_stage0 (
        .clock(clock), .rst(rst), .select(sel0), .data_in(data_q),
        .key(key0_q), .done(done0), .data_out(st0_out));

    des_decrypt u_stage1 (
        .clock(clock), .rst(rst), .select(sel1), .data_in(mid_q),
        .key(key1_q), .done(done1), .data_out(st1_out));

    des_encrypt u_stage2 (
        .clock(clock), .rst(rst), .select(sel2), .data_in(mid_q),
        .key(key2_q), .done(done2), .data_out(st2_out));
endmodule

// File: tb/tb_des3_encrypt_hs.sv
// Directed bench for des3_encrypt_hs: known-answer vectors, latency, backpressure and mid-run reset.
module tb_des3_encrypt_hs;
    localparam int LAT = 55;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [63:0] key0 = '0;
    logic [63:0] key1 = '0;
    logic [63:0] key2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_err;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    des3_encrypt_hs dut (
        .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .key0(key0), .key1(key1), .key2(key2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .busy(busy));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [63:0] k0,
                        input logic [63:0] k1, input logic [63:0] k2);
        @(negedge clock);
        in_data  = d;
        key0     = k0;
        key1     = k1;
        key2     = k2;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        key0     = 64'hFEDC_BA98_7654_3210;
        key1     = 64'h0;
        key2     = ~k2;
    endtask

    // Called one step into cycle 1; returns the cycle in which out_valid is first seen.
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle_in_ready"}, in_ready, 1'b1);
        chk({tag, "_idle_out_valid"}, out_valid, 1'b0);
    endtask

    task automatic run_vec(input string tag, input logic [63:0] d, input logic [63:0] k0,
                           input logic [63:0] k1, input logic [63:0] k2, input logic [63:0] exp);
        int cyc;
        send(d, k0, k1, k2);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_in_ready_run"}, in_ready, 1'b0);
        wait_out(cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'(LAT));
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_err"}, out_err, 1'b0);
        chk({tag, "_in_ready_out"}, in_ready, 1'b0);
        handshake(tag);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [63:0] held;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_err", out_err, 1'b0);
        rst = 1'b0;

        // Keying option 1 and equal-key vectors
        run_vec("ko1", 64'h5468_6520_7175_6663, 64'h0123_4567_89AB_CDEF,
                64'h2345_6789_ABCD_EF01, 64'h4567_89AB_CDEF_0123, 64'hA826_FD8C_E53B_855F);
        run_vec("ko3", 64'h0123_4567_89AB_CDEF, 64'h1334_5779_9BBC_DFF1,
                64'h1334_5779_9BBC_DFF1, 64'h1334_5779_9BBC_DFF1, 64'h85E8_1354_0F0A_B405);

        // Backpressure: hold the result for 20 cycles while in_valid is offered
        send(64'h0123_4567_89AB_CDEF, 64'h1334_5779_9BBC_DFF1,
             64'h1334_5779_9BBC_DFF1, 64'h1334_5779_9BBC_DFF1);
        wait_out(cyc);
        chk("bp_latency", 64'(cyc), 64'(LAT));
        held = 64'h85E8_1354_0F0A_B405;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = 64'(i) * 64'h1111_1111_1111_1111;
            @(posedge clock);
            #1;
            chk("bp_data_stable", out_data, held);
            chk("bp_in_ready_low", {out_valid, in_ready}, 2'b10);
        end
        @(negedge clock);
        in_data   = 64'h5468_6520_7175_6663;
        key0      = 64'h0123_4567_89AB_CDEF;
        key1      = 64'h2345_6789_ABCD_EF01;
        key2      = 64'h4567_89AB_CDEF_0123;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("bp_release_idle", {in_ready, out_valid, busy}, 3'b100);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("bp_next_accepted", busy, 1'b1);
        wait_out(cyc);
        chk("bp_next_latency", 64'(cyc), 64'(LAT));
        chk("bp_next_data", out_data, 64'hA826_FD8C_E53B_855F);
        handshake("bp_next");

        // Reset in the middle of the decrypt stage
        send(64'h0123_4567_89AB_CDEF, 64'h1334_5779_9BBC_DFF1,
             64'h1334_5779_9BBC_DFF1, 64'h1334_5779_9BBC_DFF1);
        repeat (24) @(posedge clock);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {in_ready, out_valid, busy, out_err}, 4'b1000);
        chk("mid_rst_out_data", out_data, 64'h0);
        @(posedge clock);
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock);
            #1;
            if (out_valid || busy) seen++;
        end
        chk("mid_rst_no_output", 64'(seen), 64'h0);
        run_vec("post_rst", 64'h0123_4567_89AB_CDEF, 64'h1334_5779_9BBC_DFF1,
                64'h1334_5779_9BBC_DFF1, 64'h1334_5779_9BBC_DFF1, 64'h85E8_1354_0F0A_B405);

`ifdef DES3_ENC_KEY_PARITY_EN
        // All-zero key0 has even parity in every byte: immediate error result
        send(64'h0123_4567_89AB_CDEF, 64'h0, 64'h2345_6789_ABCD_EF01, 64'h4567_89AB_CDEF_0123);
        chk("par_out_valid", out_valid, 1'b1);
        chk("par_out_err", out_err, 1'b1);
        chk("par_out_data", out_data, 64'h0);
        handshake("par");
        chk("par_err_cleared", out_err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
